writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter: RSP_INIT, 64'h0, reset value of register 4 (%rsp).
REQ-002 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: wb_en  input  1  an instruction is presented for write-back this cycle.
REQ-006 Port: icode  input  4  instruction code of presented instruction.
REQ-007 Port: cnd  input  1  condition result from execute (cmovxx qualifier).
REQ-008 Port: rA  input  4  register specifier A.
REQ-009 Port: rB  input  4  register specifier B.
REQ-010 Port: valE  input  64  ALU result.
REQ-011 Port: valM  input  64  memory read result.
REQ-012 Port: stat_in  input  2  instruction status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-013 Port: reg_mem0..reg_mem14  output  64 each  registered architectural register contents.
REQ-014 Port: stat_out  output  2  latched processor status, same encoding as stat_in.
REQ-015 Port: halted  output  1  processor stopped; no further write-back.
REQ-016 Port: wb_count  output  CNT_W  count of retired AOK instructions.

Function
REQ-017 dstE SHALL be: icode 2 -> rB if cnd=1 else 15; icode 3 or 6 -> rB; icode 8, 9, A, B -> 4; all others -> 15.
REQ-018 dstM SHALL be: icode 5 or B -> rA; all others -> 15.
REQ-019 Specifier 15 SHALL mean no write; no storage exists for index 15.
REQ-020 A write occurs at the rising edge only when wb_en=1, halted=0, stat_in=AOK.
REQ-021 On a write, register[dstE] <= valE and register[dstM] <= valM in the same edge.
REQ-022 When dstE==dstM and neither is 15, valM SHALL win (popq %rsp leaves popped value in %rsp).
REQ-023 Outputs are registers; a write at edge N is visible on reg_memX after edge N; no combinational path from inputs to reg_memX.
REQ-024 When wb_en=1, halted=0, stat_in!=AOK: no register write, stat_out <= stat_in, halted <= 1 at that edge.
REQ-025 While halted=1, all inputs are ignored; registers, stat_out and wb_count hold until reset.
REQ-026 wb_count increments by 1 on every edge where a write-enabled AOK instruction retires (REQ-020), including instructions whose dstE and dstM are both 15 (nop, jXX, rmmovq, not-taken cmovxx).
REQ-027 wb_count saturates at all-ones; no wrap.
REQ-028 wb_en=0 SHALL change no state (stall/bubble).
REQ-029 Unknown icode (not 0-B) with stat_in=AOK retires with no register write and increments wb_count.

Reset
REQ-030 reset=1 at a rising edge SHALL set reg_mem0..3 and reg_mem5..14 to 0, reg_mem4 to RSP_INIT, stat_out to AOK (0), halted to 0, wb_count to 0.
REQ-031 Reset SHALL take priority over any simultaneous write or halt event, including clearing an existing halted state.
REQ-032 Outputs are undefined only before the first reset edge; no asynchronous behaviour.

Verification
REQ-033 irmovq (icode 3, rB=2, valE=64'h1234) with wb_en=1 -> reg_mem2=64'h1234 after the edge; wb_count=1.
REQ-034 cmovxx (icode 2, rB=5, valE=7) with cnd=0 -> reg_mem5 unchanged, wb_count increments; repeat with cnd=1 -> reg_mem5=7.
REQ-035 popq %rsp (icode B, rA=4, valE=RSP+8, valM=64'hBEEF) -> reg_mem4=64'hBEEF; popq %rbx (rA=3) -> reg_mem3=valM and reg_mem4=valE.
REQ-036 stat_in=ADR with icode 6, rB=1 -> reg_mem1 unchanged, stat_out=2, halted=1; subsequent AOK irmovq -> no change; reset -> halted=0, reg_mem4=RSP_INIT.
REQ-037 wb_en=0 with icode 3, rB=0, valE=9 for 3 cycles -> reg_mem0 and wb_count unchanged.
REQ-038 Preload wb_count to all-ones via CNT_W=2 and 4 retirements -> wb_count stays 2'b11 on further retirements.

Source files
------------

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage and architectural register file.
// Resolves the two destination ports, commits results, latches halt status and counts retirements.
module writeback_regfile #(
    parameter logic [63:0] RSP_INIT = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_en,
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic [1:0]       stat_in,
    output logic [63:0]      reg_mem0,
    output logic [63:0]      reg_mem1,
    output logic [63:0]      reg_mem2,
    output logic [63:0]      reg_mem3,
    output logic [63:0]      reg_mem4,
    output logic [63:0]      reg_mem5,
    output logic [63:0]      reg_mem6,
    output logic [63:0]      reg_mem7,
    output logic [63:0]      reg_mem8,
    output logic [63:0]      reg_mem9,
    output logic [63:0]      reg_mem10,
    output logic [63:0]      reg_mem11,
    output logic [63:0]      reg_mem12,
    output logic [63:0]      reg_mem13,
    output logic [63:0]      reg_mem14,
    output logic [1:0]       stat_out,
    output logic             halted,
    output logic [CNT_W-1:0] wb_count
);

    localparam int unsigned NUM_REGS = 15;
    localparam logic [3:0]  REG_NONE = 4'hF;
    localparam logic [3:0]  REG_RSP  = 4'h4;
    localparam logic [1:0]  STAT_AOK = 2'd0;

    logic [63:0] regs [NUM_REGS];
    logic [3:0]  dst_e_c;
    logic [3:0]  dst_m_c;
    logic        retire_c;
    logic        fault_c;

    // Destination selection by instruction class
    always_comb begin
        dst_e_c = REG_NONE;
        dst_m_c = REG_NONE;
        case (icode)
            4'h2:                      dst_e_c = cnd ? rB : REG_NONE;
            4'h3, 4'h6:                dst_e_c = rB;
            4'h8, 4'h9, 4'hA, 4'hB:    dst_e_c = REG_RSP;
            default:                   dst_e_c = REG_NONE;
        endcase
        if (icode == 4'h5 || icode == 4'hB) begin
            dst_m_c = rA;
        end
    end

    assign retire_c = wb_en && !halted && (stat_in == STAT_AOK);
    assign fault_c  = wb_en && !halted && (stat_in != STAT_AOK);

    // The valM write is issued last so it wins when both ports target one register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= (i == int'(REG_RSP)) ? RSP_INIT : 64'h0;
            end
            stat_out <= STAT_AOK;
            halted   <= 1'b0;
            wb_count <= '0;
        end else if (retire_c) begin
            if (dst_e_c != REG_NONE) begin
                regs[dst_e_c] <= valE;
            end
            if (dst_m_c != REG_NONE) begin
                regs[dst_m_c] <= valM;
            end
            if (wb_count != {CNT_W{1'b1}}) begin
                wb_count <= wb_count + CNT_W'(1);
            end
        end else if (fault_c) begin
            stat_out <= stat_in;
            halted   <= 1'b1;
        end
    end

    assign reg_mem0  = regs[0];
    assign reg_mem1  = regs[1];
    assign reg_mem2  = regs[2];
    assign reg_mem3  = regs[3];
    assign reg_mem4  = regs[4];
    assign reg_mem5  = regs[5];
    assign reg_mem6  = regs[6];
    assign reg_mem7  = regs[7];
    assign reg_mem8  = regs[8];
    assign reg_mem9  = regs[9];
    assign reg_mem10 = regs[10];
    assign reg_mem11 = regs[11];
    assign reg_mem12 = regs[12];
    assign reg_mem13 = regs[13];
    assign reg_mem14 = regs[14];

endmodule
